// File: rtl/switch_pkg.sv
// Shared types and constants for the switch learning path.
package switch_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } sa_arb_state_t;

   localparam int cSA_WIDTH = 14;

   // Index width for a port count; never below one bit so a 2-port build still has an index.
   function automatic int clog2_ports(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo pPORTS.
module rr_arbiter
   import switch_pkg::*;
#(
   parameter int pPORTS = 4,
   localparam int cIDX_W = clog2_ports(pPORTS)
) (
   input  logic [pPORTS-1:0] req,
   input  logic [cIDX_W-1:0] last_grant,
   output logic [pPORTS-1:0] gnt,
   output logic [cIDX_W-1:0] gnt_idx,
   output logic              any_req
);

   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int off = 1; off <= pPORTS; off++) begin
         int cand;
         cand = (int'(last_grant) + off) % pPORTS;
         if (!found && req[cIDX_W'(cand)]) begin
            found               = 1'b1;
            gnt[cIDX_W'(cand)]  = 1'b1;
            gnt_idx             = cIDX_W'(cand);
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/sa_learn_arbiter.sv
// Buffers one new-SA event per receive port and serializes them onto the MAC-table write channel.
//   state | meaning
//   IDLE  | no write offered; grant next pending port if any
//   WRITE | owr_val high, write held until iwr_rdy
module sa_learn_arbiter
   import switch_pkg::*;
#(
   parameter int pPORTS    = 4,
   parameter int pSA_WIDTH = cSA_WIDTH,
   parameter int pDROP_W   = 16
) (
   input  logic                        iclk,
   input  logic                        irst,
   input  logic [pPORTS*pSA_WIDTH-1:0] isa,
   input  logic [pPORTS-1:0]           inewsa,
   output logic                        owr_val,
   output logic [pSA_WIDTH-1:0]        owr_sa,
   output logic [$clog2(pPORTS)-1:0]   owr_port,
   input  logic                        iwr_rdy,
   output logic [pPORTS*pDROP_W-1:0]   odrop_cnt,
   output logic                        obusy
);

   localparam int cIDX_W = clog2_ports(pPORTS);

   sa_arb_state_t        state;
   logic [pPORTS-1:0]    pend;
   logic [pSA_WIDTH-1:0] sa_buf [pPORTS];
   logic [pDROP_W-1:0]   drop_cnt [pPORTS];
   logic [cIDX_W-1:0]    last_grant;
   logic [pPORTS-1:0]    gnt_r;
   logic [pPORTS-1:0]    acc_vec;

   logic [pPORTS-1:0]    arb_gnt;
   logic [cIDX_W-1:0]    arb_idx;
   logic                 any_req;

   rr_arbiter #(.pPORTS(pPORTS)) u_rr (
      .req        (pend),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx),
      .any_req    (any_req)
   );

   // One-hot of the port whose write completes at this edge.
   always_comb begin
      acc_vec = '0;
      if (state == WRITE && iwr_rdy) acc_vec = gnt_r;
   end

   for (genvar g = 0; g < pPORTS; g++) begin : g_drop
      assign odrop_cnt[g*pDROP_W +: pDROP_W] = drop_cnt[g];
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state      <= IDLE;
         owr_val    <= 1'b0;
         owr_sa     <= '0;
         owr_port   <= '0;
         gnt_r      <= '0;
         last_grant <= cIDX_W'(pPORTS - 1);
         obusy      <= 1'b0;
         pend       <= '0;
         for (int p = 0; p < pPORTS; p++) begin
            sa_buf[p]   <= '0;
            drop_cnt[p] <= '0;
         end
      end else begin
         obusy <= (|pend) || (state == WRITE);

         // A port being accepted this cycle can take a new event without counting a drop.
         for (int p = 0; p < pPORTS; p++) begin
            if (inewsa[p]) begin
               if (!pend[p] || acc_vec[p]) begin
                  sa_buf[p] <= isa[p*pSA_WIDTH +: pSA_WIDTH];
                  pend[p]   <= 1'b1;
               end else if (drop_cnt[p] != {pDROP_W{1'b1}}) begin
                  drop_cnt[p] <= drop_cnt[p] + 1'b1;
               end
            end else if (acc_vec[p]) begin
               pend[p] <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (any_req) begin
                  owr_val  <= 1'b1;
                  owr_sa   <= sa_buf[arb_idx];
                  owr_port <= arb_idx;
                  gnt_r    <= arb_gnt;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (iwr_rdy) begin
                  owr_val    <= 1'b0;
                  last_grant <= owr_port;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_learn_arbiter.sv
// Self-checking bench for sa_learn_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_sa_learn_arbiter;

   localparam int P = 4;
   localparam int W = 14;
   localparam int D = 16;

   logic             iclk = 1'b0;
   logic             irst = 1'b1;
   logic [P*W-1:0]   isa = '0;
   logic [P-1:0]     inewsa = '0;
   logic             owr_val;
   logic [W-1:0]     owr_sa;
   logic [1:0]       owr_port;
   logic             iwr_rdy = 1'b0;
   logic [P*D-1:0]   odrop_cnt;
   logic             obusy;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit m_pend [P];
   int m_sa   [P];
   int m_drop [P];
   bit m_val;
   int m_osa;
   int m_oport;
   int m_last;
   bit m_busy;

   sa_learn_arbiter #(.pPORTS(P), .pSA_WIDTH(W), .pDROP_W(D)) dut (
      .iclk      (iclk),
      .irst      (irst),
      .isa       (isa),
      .inewsa    (inewsa),
      .owr_val   (owr_val),
      .owr_sa    (owr_sa),
      .owr_port  (owr_port),
      .iwr_rdy   (iwr_rdy),
      .odrop_cnt (odrop_cnt),
      .obusy     (obusy)
   );

   always #5 iclk = ~iclk;

   task automatic model_reset();
      for (int p = 0; p < P; p++) begin
         m_pend[p] = 0;
         m_sa[p]   = 0;
         m_drop[p] = 0;
      end
      m_val = 0; m_osa = 0; m_oport = 0; m_busy = 0; m_last = P - 1;
   endtask

   task automatic model_step(input bit rst, input logic [P-1:0] nw,
                             input logic [P*W-1:0] sa, input bit rdy);
      bit old_pend [P];
      int old_sa [P];
      bit any_pend;
      bit acc;
      int acc_port;
      int g;
      if (rst) begin
         model_reset();
         return;
      end
      any_pend = 0;
      for (int p = 0; p < P; p++) begin
         old_pend[p] = m_pend[p];
         old_sa[p]   = m_sa[p];
         if (m_pend[p]) any_pend = 1;
      end
      m_busy   = any_pend || m_val;
      acc      = m_val && rdy;
      acc_port = m_oport;
      if (m_val) begin
         if (rdy) begin
            m_val  = 0;
            m_last = m_oport;
         end
      end else begin
         g = -1;
         for (int k = 1; k <= P; k++) begin
            int c;
            c = (m_last + k) % P;
            if (g < 0 && old_pend[c]) g = c;
         end
         if (g >= 0) begin
            m_val   = 1;
            m_osa   = old_sa[g];
            m_oport = g;
         end
      end
      for (int p = 0; p < P; p++) begin
         if (nw[p]) begin
            if (!old_pend[p] || (acc && acc_port == p)) begin
               m_sa[p]   = int'(sa[p*W +: W]);
               m_pend[p] = 1;
            end else if (m_drop[p] < (1 << D) - 1) begin
               m_drop[p] = m_drop[p] + 1;
            end
         end else if (acc && acc_port == p) begin
            m_pend[p] = 0;
         end
      end
   endtask

   // Advance one clock; the model sees the inputs that were present at the edge.
   task automatic cyc();
      bit             r;
      logic [P-1:0]   n;
      logic [P*W-1:0] s;
      bit             y;
      r = irst; n = inewsa; s = isa; y = iwr_rdy;
      @(posedge iclk);
      model_step(r, n, s, y);
      #1;
   endtask

   task automatic do_reset();
      irst = 1'b1; inewsa = '0; iwr_rdy = 1'b0; isa = '0;
      cyc();
      irst = 1'b0;
   endtask

   task automatic test_reset();
      irst = 1'b1; inewsa = '1; isa = {P*W{1'b1}}; iwr_rdy = 1'b1;
      cyc();
      cyc();
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL reset_val got=%0b exp=0", owr_val); end
      checks++; if (owr_sa !== '0) begin errors++; $display("FAIL reset_sa got=%h exp=0", owr_sa); end
      checks++; if (owr_port !== '0) begin errors++; $display("FAIL reset_port got=%0d exp=0", owr_port); end
      checks++; if (odrop_cnt !== '0) begin errors++; $display("FAIL reset_drop got=%h exp=0", odrop_cnt); end
      checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", obusy); end
      irst = 1'b0; inewsa = '0; isa = '0; iwr_rdy = 1'b0;
      cyc();
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL reset_idle_val got=%0b exp=0", owr_val); end
   endtask

   task automatic test_single();
      do_reset();
      iwr_rdy = 1'b1;
      inewsa = 4'b0001; isa[0 +: W] = 14'h1A5;
      cyc();
      inewsa = '0;
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL single_t1_val got=%0b exp=0", owr_val); end
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_sa !== 14'h1A5 || owr_port !== 2'd0) begin
         errors++; $display("FAIL single_t2 got val=%0b sa=%h port=%0d exp val=1 sa=1a5 port=0", owr_val, owr_sa, owr_port);
      end
      cyc();
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL single_t3_val got=%0b exp=0", owr_val); end
      cyc();
      checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL single_t4_busy got=%0b exp=0", obusy); end
      iwr_rdy = 1'b0;
   endtask

   task automatic test_round_robin();
      int n;
      do_reset();
      iwr_rdy = 1'b1;
      inewsa = 4'b1111;
      isa = {14'h40, 14'h30, 14'h20, 14'h10};
      cyc();
      inewsa = '0;
      n = 0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (owr_val === 1'b1) begin
            checks++;
            if (owr_port !== 2'(n) || owr_sa !== 14'((n + 1) * 16) || k != 1 + 2 * n) begin
               errors++;
               $display("FAIL rr_write got port=%0d sa=%h step=%0d exp port=%0d sa=%h step=%0d",
                        owr_port, owr_sa, k, n, (n + 1) * 16, 1 + 2 * n);
            end
            n++;
         end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
      iwr_rdy = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      inewsa = 4'b0100; isa = '0; isa[2*W +: W] = 14'h2BC;
      cyc();
      inewsa = '0;
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd2 || owr_sa !== 14'h2BC) begin
         errors++; $display("FAIL bp_grant got val=%0b port=%0d sa=%h exp val=1 port=2 sa=2bc", owr_val, owr_port, owr_sa);
      end
      for (int k = 0; k < 10; k++) begin
         cyc();
         checks++; if (owr_val !== 1'b1 || owr_port !== 2'd2 || owr_sa !== 14'h2BC) begin
            errors++; $display("FAIL bp_hold got val=%0b port=%0d sa=%h exp val=1 port=2 sa=2bc", owr_val, owr_port, owr_sa);
         end
      end
      iwr_rdy = 1'b1;
      cyc();
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL bp_complete got=%0b exp=0", owr_val); end
      iwr_rdy = 1'b0;
   endtask

   task automatic test_drop_count();
      do_reset();
      inewsa = 4'b0010; isa = '0; isa[1*W +: W] = 14'h111;
      cyc();
      isa[1*W +: W] = 14'h3FF;
      for (int k = 0; k < 3; k++) begin
         inewsa = '0;
         cyc();
         inewsa = 4'b0010;
         cyc();
      end
      inewsa = '0;
      cyc();
      checks++; if (odrop_cnt[1*D +: D] !== 16'd3 || odrop_cnt[0 +: D] !== '0) begin
         errors++; $display("FAIL drop_three got=%h exp port1=3 others=0", odrop_cnt);
      end
      inewsa = 4'b0010;
      for (int k = 0; k < 65532; k++) cyc();
      checks++; if (odrop_cnt[1*D +: D] !== 16'hFFFF) begin
         errors++; $display("FAIL drop_reach_max got=%h exp=ffff", odrop_cnt[1*D +: D]);
      end
      for (int k = 0; k < 4; k++) cyc();
      checks++; if (odrop_cnt[1*D +: D] !== 16'hFFFF) begin
         errors++; $display("FAIL drop_saturate got=%h exp=ffff", odrop_cnt[1*D +: D]);
      end
      inewsa = '0;
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd1 || owr_sa !== 14'h111) begin
         errors++; $display("FAIL drop_orig_sa got val=%0b port=%0d sa=%h exp val=1 port=1 sa=111", owr_val, owr_port, owr_sa);
      end
      iwr_rdy = 1'b1;
      cyc();
      checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL drop_accept got=%0b exp=0", owr_val); end
      iwr_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      inewsa = 4'b1000; isa = '0; isa[3*W +: W] = 14'h0AA;
      cyc();
      inewsa = '0;
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd3 || owr_sa !== 14'h0AA) begin
         errors++; $display("FAIL b2b_first got val=%0b port=%0d sa=%h exp val=1 port=3 sa=0aa", owr_val, owr_port, owr_sa);
      end
      iwr_rdy = 1'b1;
      inewsa = 4'b1000; isa[3*W +: W] = 14'h0BB;
      cyc();
      inewsa = '0;
      checks++; if (odrop_cnt[3*D +: D] !== '0) begin
         errors++; $display("FAIL b2b_nodrop got=%h exp=0", odrop_cnt[3*D +: D]);
      end
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd3 || owr_sa !== 14'h0BB) begin
         errors++; $display("FAIL b2b_second got val=%0b port=%0d sa=%h exp val=1 port=3 sa=0bb", owr_val, owr_port, owr_sa);
      end
      cyc();
      iwr_rdy = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      inewsa = 4'b0110; isa = '0; isa[1*W +: W] = 14'h055; isa[2*W +: W] = 14'h066;
      cyc();
      inewsa = '0;
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd1) begin
         errors++; $display("FAIL rstmid_pre got val=%0b port=%0d exp val=1 port=1", owr_val, owr_port);
      end
      irst = 1'b1;
      cyc();
      irst = 1'b0;
      checks++; if (owr_val !== 1'b0 || owr_sa !== '0 || owr_port !== '0 || obusy !== 1'b0 || odrop_cnt !== '0) begin
         errors++; $display("FAIL rstmid_outputs got val=%0b sa=%h port=%0d busy=%0b drop=%h exp all zero",
                            owr_val, owr_sa, owr_port, obusy, odrop_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++; if (owr_val !== 1'b0) begin errors++; $display("FAIL rstmid_discard got=%0b exp=0", owr_val); end
      end
      inewsa = 4'b0101; isa[0 +: W] = 14'h0C0; isa[2*W +: W] = 14'h0C2;
      cyc();
      inewsa = '0;
      cyc();
      checks++; if (owr_val !== 1'b1 || owr_port !== 2'd0 || owr_sa !== 14'h0C0) begin
         errors++; $display("FAIL rstmid_first got val=%0b port=%0d sa=%h exp val=1 port=0 sa=0c0", owr_val, owr_port, owr_sa);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         irst = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < P; p++) begin
            inewsa[p] = ($urandom_range(0, 3) == 0);
            isa[p*W +: W] = W'($urandom);
         end
         iwr_rdy = $urandom_range(0, 1) == 1;
         cyc();
         checks++;
         if (owr_val !== m_val || owr_sa !== W'(m_osa) || owr_port !== 2'(m_oport) || obusy !== m_busy) begin
            errors++;
            if (errors < 20)
               $display("FAIL rand_out cyc=%0d got val=%0b sa=%h port=%0d busy=%0b exp val=%0b sa=%h port=%0d busy=%0b",
                        k, owr_val, owr_sa, owr_port, obusy, m_val, m_osa, m_oport, m_busy);
         end
         for (int p = 0; p < P; p++) begin
            checks++;
            if (odrop_cnt[p*D +: D] !== D'(m_drop[p])) begin
               errors++;
               if (errors < 20)
                  $display("FAIL rand_drop cyc=%0d port=%0d got=%0d exp=%0d", k, p, odrop_cnt[p*D +: D], m_drop[p]);
            end
         end
      end
      irst = 1'b0; inewsa = '0; iwr_rdy = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_drop_count();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sa_learn_arbiter.md
# sa_learn_arbiter

Collects new-source-address events from the switch's receive ports and serializes them into a single MAC-table write channel. Each port's frame receiver pulses `onewsa` with a 14-bit SA hash. This block buffers one event per port, picks among the pending ports by round-robin, and presents one write at a time to the learning table over a valid/ready handshake. It sits between the per-port receiver instances and the shared learning/forwarding table, and counts events dropped because a port's buffer was still occupied.

## Interface
Parameters:
- `pPORTS`, default 4: number of receive ports. Legal range 2..16.
- `pSA_WIDTH`, default 14: SA hash width; matches the receiver `osa` width.
- `pDROP_W`, default 16: width of each per-port drop counter.

Ports:
- `iclk` in, 1 bit: single clock for the whole block.
- `irst` in, 1 bit: synchronous, active-high reset.
- `isa` in, `pPORTS*pSA_WIDTH` bits: per-port SA hash. Port p occupies bits `[p*pSA_WIDTH +: pSA_WIDTH]`.
- `inewsa` in, `pPORTS` bits: per-port one-cycle pulse meaning `isa` of that port is valid this cycle.
- `owr_val` out, 1 bit: a table write is offered.
- `owr_sa` out, `pSA_WIDTH` bits: SA hash of the offered write.
- `owr_port` out, `$clog2(pPORTS)` bits: source port of the offered write.
- `iwr_rdy` in, 1 bit: the table accepts the offered write this cycle.
- `odrop_cnt` out, `pPORTS*pDROP_W` bits: per-port saturating drop counters.
- `obusy` out, 1 bit: high if any port is pending or the FSM is in WRITE.

## Operation
- Per-port pending buffer: a `pend` flag plus an SA register.
  - On `inewsa[p]` with `pend[p]`=0, latch `isa[p]` and set `pend[p]`.
  - On `inewsa[p]` with `pend[p]`=1 and no acceptance of port p this cycle, drop the new event: the buffer keeps its old SA and `drop_cnt[p]` increments, saturating at all-ones.
  - On `inewsa[p]` in the same cycle that port p's write is accepted, load the new SA, keep `pend[p]`=1, and count no drop.
- FSM states are IDLE and WRITE.
  - IDLE: if any `pend` is set, grant the first pending port searching from `last_grant+1` modulo `pPORTS`. Register `owr_sa`/`owr_port` from that port's buffer and go to WRITE. Otherwise stay in IDLE.
  - WRITE: `owr_val`=1. `owr_sa`/`owr_port` are held stable until `iwr_rdy`=1. On acceptance, clear the granted `pend` (unless reloaded as above), set `last_grant` to the granted port, and return to IDLE.
- `owr_val` never deasserts without acceptance, except on `irst`.
- Events arriving on a port while that port is granted and waiting are subject to the drop rule above.

## Timing
- Reset values:
  - `owr_val`=0, `owr_sa`=0, `owr_port`=0.
  - All `pend`=0 and all `odrop_cnt`=0.
  - `obusy`=0, FSM in IDLE.
  - `last_grant`=`pPORTS-1`, so port 0 has first priority.
- Latency from an `inewsa` pulse at cycle t (idle block) to `owr_val`=1 is 2 cycles:
  - the buffer is set at t+1;
  - the grant is registered and `owr_val` rises at t+2.
- Throughput is at most one write per 2 cycles: the acceptance cycle is followed by one cycle in IDLE.
- `irst` asserted mid-WRITE: `owr_val`=0 on the next cycle and all pending events are discarded. Drops are not counted for events discarded by reset.
- `obusy` is registered and reflects `pend` and the FSM state as of the previous edge.
- Outputs are registered, with no combinational path from `iwr_rdy` or `inewsa` to any output.

## Structure
- Shared package `switch_pkg` holds:
  - the state enum `sa_arb_state_t` {IDLE, WRITE};
  - the constant `cSA_WIDTH`=14;
  - the function `clog2_ports`.
- Sub-module `rr_arbiter`:
  - parameterized on `pPORTS`;
  - inputs are the request vector and `last_grant`;
  - outputs are the one-hot grant, the grant index and an any-request flag;
  - purely combinational, instantiated once.
- The top level holds the buffers, drop counters and FSM.

## Test plan
- Single event: `inewsa`=4'b0001, `isa[0]`=14'h1A5 at cycle t. Expect `owr_val` at t+2 with `owr_sa`=14'h1A5 and `owr_port`=0. With `iwr_rdy`=1, `obusy`=0 by t+4.
- Round-robin: `inewsa`=4'b1111 in one cycle with SAs 14'h10, 14'h20, 14'h30, 14'h40 and `iwr_rdy` tied high. Expect writes on ports 0,1,2,3 in that order, 2 cycles apart.
- Backpressure: `iwr_rdy`=0 for 10 cycles with port 2 granted. `owr_val`, `owr_sa` and `owr_port` stay constant throughout; the write completes on the cycle `iwr_rdy` rises.
- Drop counting: while port 1 is pending and `iwr_rdy`=0, pulse `inewsa[1]` 3 times. Expect `odrop_cnt[1]`=3, and the original SA is still the one written. Force the counter to 16'hFFFF and pulse once more: the counter stays 16'hFFFF.
- Simultaneous accept and new event on the same port: expect no drop, and the second SA written on the next grant of that port.
- Reset mid-WRITE: assert `irst` while `owr_val`=1. Expect all outputs at their reset values the next cycle, and port 0 granted first afterwards.
